// File: rtl/id_tagger_if.sv
// id_tagger_if: upstream word stream plus downstream (data, id) stream.
// The tagger takes the slave side, its environment the master side.
interface id_tagger_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ID_WIDTH-1:0]   out_id;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/id_tagger.sv
// id_tagger: stamps accepted words with a running ID, buffers pairs in a FIFO.
// Define ID_TAGGER_STATS_EN to add the stall_cnt upstream-stall counter.
module id_tagger #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  ID_WIDTH   = 32,
    parameter int                  DEPTH      = 4,
    parameter logic [ID_WIDTH-1:0] ID_START   = '0,
    localparam int                 AW         = $clog2(DEPTH),
    localparam int                 LW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_clr,
    id_tagger_if.slave    bus,
    output logic [LW-1:0] level
`ifdef ID_TAGGER_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    logic [DATA_WIDTH-1:0] dmem_q [DEPTH];
    logic [ID_WIDTH-1:0]   imem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   tag;
    logic                  en_q;
    logic                  in_rdy;
    logic                  out_vld;
    logic                  push;
    logic                  pop;

    // en_q keeps in_ready low until the first edge after reset release
    assign in_rdy  = en_q && (level_q != LW'(DEPTH));
    assign out_vld = (level_q != '0);
    assign push    = bus.in_valid & in_rdy;
    assign pop     = out_vld & bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? dmem_q[rd_ptr_q] : '0;
    assign bus.out_id    = out_vld ? imem_q[rd_ptr_q] : '0;
    assign level         = level_q;

    assign tag = id_clr ? ID_START : id_q;

    always_comb begin
        id_d     = push ? tag + 1'b1 : tag;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        unique case (1'b1)
            push & ~pop: level_d = level_q + 1'b1;
            pop & ~push: level_d = level_q - 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            id_q     <= ID_START;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            id_q     <= id_d;
            en_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem_q[i] <= '0;
                imem_q[i] <= '0;
            end
        end else if (push) begin
            dmem_q[wr_ptr_q] <= bus.in_data;
            imem_q[wr_ptr_q] <= tag;
        end
    end

`ifdef ID_TAGGER_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (id_clr)
            stall_d = '0;
        else if (bus.in_valid && !in_rdy && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/id_tagger.md
Name: id_tagger

Overview:
- Upstream stage that feeds the data/id consumer.
- Accepts a raw data stream over a valid/ready handshake.
- Stamps each accepted word with a monotonically incrementing ID and buffers the (data, id) pairs in a small FIFO.
- Presents pairs downstream on a valid/ready interface as the consumer's `data` and `id` inputs.

Parameters:
- DATA_WIDTH, 8, width of in_data/out_data
- ID_WIDTH, 32, width of ID counter and out_id
- DEPTH, 4, FIFO entries; power of two, >= 2
- ID_START, 0, value loaded into the ID counter at reset and on id_clr

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_clr  input  1  synchronous clear of the ID counter
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_data  input  DATA_WIDTH  upstream word
- out_valid  output  1  head pair valid
- out_ready  input  1  downstream accepts head pair
- out_data  output  DATA_WIDTH  head data
- out_id  output  ID_WIDTH  head ID
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset is asynchronous and active-low on rst_n, with one clock clk.
- While rst_n=0:
  - FIFO empty, rd/wr pointers 0, level=0.
  - ID counter=ID_START.
  - in_ready=0, out_valid=0, out_data=0, out_id=0.
- After deassertion, in_ready=1 from the first clk edge.
- Reset asserted mid-operation discards all buffered pairs immediately (async). No partial pair is emitted.
- Accept: a push occurs on a clk edge with in_valid & in_ready.
  - Entry written = {in_data, current ID}.
  - ID counter increments by 1, modulo 2^ID_WIDTH. All-ones wraps to 0; no saturation or flag.
- Pop: occurs on a clk edge with out_valid & out_ready. The read pointer advances.
- in_ready = (level != DEPTH). No combinational path from out_ready to in_ready; when full, no push even if a pop happens in the same cycle.
- out_valid = (level != 0).
- out_data/out_id are driven from the head entry. When out_valid=0 they hold 0.
- Latency: a word accepted at edge N is visible on out_* after edge N (cycle N+1). There is no same-cycle bypass.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Push when level==DEPTH: impossible (in_ready=0). Upstream must hold in_valid/in_data stable until accepted.
- Downstream stall (out_valid=1, out_ready=0): out_data/out_id remain stable.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are tracked by level.
- id_clr:
  - On an edge with id_clr=1, the counter loads ID_START.
  - If a push occurs in the same cycle, the pushed word is tagged ID_START and the counter becomes ID_START+1.
  - Buffered entries keep their existing IDs.
- IDs are contiguous across accepted words. Cycles without a push do not consume IDs.

Optional Feature:
- Macro ID_TAGGER_STATS_EN.
- With the macro defined:
  - Extra output port stall_cnt, output, 16 bits.
  - Counts clk cycles with in_valid=1 & in_ready=0; saturates at 16'hFFFF.
  - Reset to 0 by rst_n and cleared by id_clr.
- Without the macro: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then push 0xA1, 0xB2, 0xC3 back-to-back with out_ready=1.
  - Expect out pairs (0xA1,0), (0xB2,1), (0xC3,2).
  - Each out_valid appears one cycle after its accept.
- Hold out_ready=0 and push 5 words (DEPTH=4).
  - Expect in_ready=0 after the 4th accept, level=4, the 5th word held upstream.
  - Release out_ready: the 5th word gets ID 4, order preserved.
- Preload counter near wrap: ID_WIDTH=4, ID_START=14, push 4 words.
  - Expect IDs 14, 15, 0, 1.
- Assert id_clr in the same cycle as accepting 0x55 after 3 prior words.
  - Expect 0x55 tagged ID_START, the next word tagged ID_START+1.
  - Earlier buffered IDs 0, 1, 2 unchanged.
- Pull rst_n low mid-cycle with level=3.
  - Expect out_valid=0, level=0, out_data/out_id=0 immediately.
  - After release, the first push gets ID_START.
- With ID_TAGGER_STATS_EN: fill FIFO, then hold in_valid=1 for 10 cycles with out_ready=0.
  - Expect stall_cnt=10; id_clr returns it to 0.
